// File: rtl/imm_encode.sv
// imm_encode: packs a 32-bit immediate into the I/S/B/J/U field positions of
// a base RV32I instruction word (the inverse of the core's immediate
// extender). Two-stage valid/ready pipeline with an error code per word, a
// saturating error counter and an optional round-trip self-check.
//
// Optional feature macro: IMM_ROUNDTRIP_CHECK_EN
//   defined   -> stage 2 re-extracts the immediate from the packed word and
//                sets the sticky rt_fail flag on a clean word that does not
//                decode back to its source immediate.
//   undefined -> no checker; rt_fail is tied to 0.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. The producer holds valid and its payload stable
// while valid=1 and ready=0. in_ready is combinational from out_ready:
// in_ready = !s1_valid || s2_advance, s2_advance = !out_valid || out_ready.
// There is no skid buffer, so at most two words are held under backpressure,
// and words leave in the order they arrived.

module imm_encode #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] instr,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic             rt_fail
);

  // Immediate type encodings; 101..111 are illegal.
  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;

  // Error codes, ordered by priority: illegal > misaligned > out of range.
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_SRC   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: captured inputs plus the error classification.
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_src_q,   s1_src_d;
  logic [WIDTH-1:0] s1_imm_q,   s1_imm_d;
  logic [WIDTH-1:0] s1_base_q,  s1_base_d;
  logic [1:0]       s1_err_q,   s1_err_d;

  // Stage 2: packed instruction and its error code (the output register).
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_instr_q, s2_instr_d;
  logic [1:0]       s2_err_q,   s2_err_d;

  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

  // Flow control.
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic s1_to_s2;
  logic out_fire;

  // Classification helpers on the raw input.
  logic sext_11_ok;
  logic sext_12_ok;
  logic sext_20_ok;
  logic u_low_zero;
  logic [1:0] in_err;

  // Packed word built from the stage-1 registers.
  logic [WIDTH-1:0] packed_word;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s1_to_s2 = s1_valid_q && s2_adv;
  assign out_fire = s2_valid_q && out_ready;

  // A field of n bits fits when every bit above it equals its sign bit.
  assign sext_11_ok = (&imm[31:11]) || !(|imm[31:11]);
  assign sext_12_ok = (&imm[31:12]) || !(|imm[31:12]);
  assign sext_20_ok = (&imm[31:20]) || !(|imm[31:20]);
  assign u_low_zero = !(|imm[11:0]);

  // Classify the incoming immediate against the selected type.
  always_comb begin
    in_err = ERR_OK;
    unique case (immsrc)
      SRC_I, SRC_S: begin
        if (!sext_11_ok) in_err = ERR_RANGE;
      end
      SRC_B: begin
        if (imm[0])           in_err = ERR_ALIGN;
        else if (!sext_12_ok) in_err = ERR_RANGE;
      end
      SRC_J: begin
        if (imm[0])           in_err = ERR_ALIGN;
        else if (!sext_20_ok) in_err = ERR_RANGE;
      end
      SRC_U: begin
        if (!u_low_zero) in_err = ERR_RANGE;
      end
      default: in_err = ERR_SRC;
    endcase
  end

  // Stage 1 next state: advance when empty or when stage 2 advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_src_d  = immsrc;
      s1_imm_d  = imm;
      s1_base_d = base;
      s1_err_d  = in_err;
    end
  end

  // Scatter the stage-1 immediate into the field positions of the base word.
  // Range/alignment errors still pack the truncated bits; an illegal type
  // leaves the base word untouched.
  always_comb begin
    packed_word = s1_base_q;
    unique case (s1_src_q)
      SRC_I: begin
        packed_word[31:20] = s1_imm_q[11:0];
      end
      SRC_S: begin
        packed_word[31:25] = s1_imm_q[11:5];
        packed_word[11:7]  = s1_imm_q[4:0];
      end
      SRC_B: begin
        packed_word[31]    = s1_imm_q[12];
        packed_word[30:25] = s1_imm_q[10:5];
        packed_word[11:8]  = s1_imm_q[4:1];
        packed_word[7]     = s1_imm_q[11];
      end
      SRC_J: begin
        packed_word[31]    = s1_imm_q[20];
        packed_word[30:21] = s1_imm_q[10:1];
        packed_word[20]    = s1_imm_q[11];
        packed_word[19:12] = s1_imm_q[19:12];
      end
      SRC_U: begin
        packed_word[31:12] = s1_imm_q[31:12];
      end
      default: packed_word = s1_base_q;
    endcase
  end

  // Stage 2 next state: advance when empty or the consumer takes the word.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_to_s2) begin
      s2_instr_d = packed_word;
      s2_err_d   = s1_err_q;
    end
  end

  // Error counter: clear wins, otherwise saturating count of errored outputs.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_fire && (s2_err_q != ERR_OK) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s1_err_q   <= ERR_OK;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= ERR_OK;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = s2_instr_q;
  assign err_code  = s2_err_q;
  assign err_cnt   = err_cnt_q;

`ifdef IMM_ROUNDTRIP_CHECK_EN
  // Source immediate and type travel alongside the packed word for the check.
  logic [2:0]       s2_src_q;
  logic [WIDTH-1:0] s2_imm_q;
  logic             rt_fail_q, rt_fail_d;
  logic [WIDTH-1:0] rex_imm;

  // Decode the packed word exactly as the core's immediate extender does.
  always_comb begin
    rex_imm = '0;
    unique case (s2_src_q)
      SRC_I: rex_imm = {{20{s2_instr_q[31]}}, s2_instr_q[31:20]};
      SRC_S: rex_imm = {{20{s2_instr_q[31]}}, s2_instr_q[31:25], s2_instr_q[11:7]};
      SRC_B: rex_imm = {{19{s2_instr_q[31]}}, s2_instr_q[31], s2_instr_q[7],
                        s2_instr_q[30:25], s2_instr_q[11:8], 1'b0};
      SRC_J: rex_imm = {{11{s2_instr_q[31]}}, s2_instr_q[31], s2_instr_q[19:12],
                        s2_instr_q[20], s2_instr_q[30:21], 1'b0};
      SRC_U: rex_imm = {s2_instr_q[31:12], 12'h000};
      default: rex_imm = '0;
    endcase
  end

  // Sticky flag: a clean word leaving the block must decode to its source.
  always_comb begin
    rt_fail_d = rt_fail_q;
    if (out_fire && (s2_err_q == ERR_OK) && (rex_imm != s2_imm_q)) begin
      rt_fail_d = 1'b1;
    end
  end

  // Side-band registers for the round-trip check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_src_q  <= '0;
      s2_imm_q  <= '0;
      rt_fail_q <= 1'b0;
    end else begin
      if (s1_to_s2) begin
        s2_src_q <= s1_src_q;
        s2_imm_q <= s1_imm_q;
      end
      rt_fail_q <= rt_fail_d;
    end
  end

  assign rt_fail = rt_fail_q;
`else
  assign rt_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: vector table with hand-computed results,
// scoreboard on the output handshake, plus sequences for latency,
// backpressure, mid-flight reset and error-counter edges.

module tb_imm_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immsrc;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;
  logic        err_clr;
  logic        rt_fail;

  imm_encode #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immsrc    (immsrc),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err_code  (err_code),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
    .rt_fail   (rt_fail)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic [1:0]  exp_err;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  logic [33:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_hs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expected word.
  always begin
    logic [33:0] e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_unexpected: got instr 0x%0h, required no output", instr);
      end else begin
        e = exp_q.pop_front();
        chk("out_instr", instr, e[31:0]);
        chk("out_err", {30'd0, err_code}, {30'd0, e[33:32]});
      end
    end
  end

  // Driver: present one word and wait (bounded) for its acceptance edge.
  // Returns #1 after the accepting edge with in_valid still high.
  task automatic send(input vec_t v);
    logic acc;
    in_valid = 1'b1;
    immsrc   = v.immsrc;
    imm      = v.imm;
    base     = v.base;
    acc      = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      exp_q.push_back({v.exp_err, v.exp_instr});
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0, required 1 within 200 cycles");
      in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until every expected word has left the block.
  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b,
                              input logic [31:0] ei, input logic [1:0] ee);
    vec_t v;
    v.immsrc = s; v.imm = i; v.base = b; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    int hs0;
    // Legal encodes (0..9)
    vecs[0]  = mk(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
    vecs[1]  = mk(3'b001, 32'h0000_0024, 32'h0000_2023, 32'h0200_2223, 2'b00);
    vecs[2]  = mk(3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 2'b00);
    vecs[3]  = mk(3'b011, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 2'b00);
    vecs[4]  = mk(3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'b00);
    vecs[5]  = mk(3'b000, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 2'b00);
    vecs[6]  = mk(3'b000, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 2'b00);
    vecs[7]  = mk(3'b011, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 2'b00);
    vecs[8]  = mk(3'b001, 32'hFFFF_F800, 32'h0000_2023, 32'h8000_2023, 2'b00);
    vecs[9]  = mk(3'b010, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 2'b00);
    // The four basic errors (10..13)
    vecs[10] = mk(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 2'b01);
    vecs[11] = mk(3'b010, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 2'b10);
    vecs[12] = mk(3'b100, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 2'b01);
    vecs[13] = mk(3'b101, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11);
    // Priority and boundary errors (14..17)
    vecs[14] = mk(3'b010, 32'h0000_2001, 32'h0000_0063, 32'h0000_0063, 2'b10);
    vecs[15] = mk(3'b011, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 2'b01);
    vecs[16] = mk(3'b111, 32'h0000_0003, 32'h0000_0013, 32'h0000_0013, 2'b11);
    vecs[17] = mk(3'b001, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 2'b01);

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    immsrc = '0; imm = '0; base = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_instr",     instr,              32'd0);
    chk("rst_err_code",  {30'd0, err_code},  32'd0);
    chk("rst_err_cnt",   {16'd0, err_cnt},   32'd0);
    chk("rst_rt_fail",   {31'd0, rt_fail},   32'd0);

    // Latency: out_valid appears exactly two cycles after the accept.
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vecs[0]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Legal words streamed back to back
    for (int i = 1; i < 10; i++) send(vecs[i]);
    in_valid = 1'b0;
    drain();
    chk("legal_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("legal_rt_fail", {31'd0, rt_fail}, 32'd0);

    // The four basic errors
    for (int i = 10; i < 14; i++) send(vecs[i]);
    in_valid = 1'b0;
    drain();
    chk("err4_err_cnt", {16'd0, err_cnt}, 32'd4);

    // Priority and boundary errors
    for (int i = 14; i < NVEC; i++) send(vecs[i]);
    in_valid = 1'b0;
    drain();
    chk("err8_err_cnt", {16'd0, err_cnt}, 32'd8);

    // Backpressure: four words in, consumer stalled for six cycles.
    hs0 = n_hs;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(vecs[k]);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (c >= 2) begin
            chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
            chk("bp_out_valid",  {31'd0, out_valid}, 32'd1);
            chk("bp_hold_instr", instr, vecs[0].exp_instr);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("bp_stream_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();
    chk("bp_word_count", n_hs - hs0, 32'd4);

    // Reset with two words buffered: they must never appear.
    out_ready = 1'b0;
    send(vecs[10]);
    send(vecs[11]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("rstmid_pre_cnt",   {16'd0, err_cnt},   32'd8);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_err_cnt",   {16'd0, err_cnt},   32'd0);
    chk("rstmid_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rstmid_instr",     instr,              32'd0);
    hs0 = n_hs;
    repeat (6) @(negedge clk);
    chk("rstmid_no_output", n_hs - hs0, 32'd0);

    // Counter saturation: preload near the top, then two more errors.
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    @(negedge clk);
    chk("cnt_preload", {16'd0, err_cnt}, 32'h0000_FFFE);
    @(posedge clk); #1;
    send(vecs[13]);
    in_valid = 1'b0;
    drain();
    chk("cnt_reach_max", {16'd0, err_cnt}, 32'h0000_FFFF);
    send(vecs[12]);
    in_valid = 1'b0;
    drain();
    chk("cnt_saturated", {16'd0, err_cnt}, 32'h0000_FFFF);

    // err_clr coincident with an errored output handshake
    out_ready = 1'b0;
    send(vecs[13]);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("clr_setup_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    err_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_coincident", {16'd0, err_cnt}, 32'd0);
    drain();

    // Final state
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_rt_fail", {31'd0, rt_fail}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
